// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a data-memory handshake.
// Optional MC_CTRL_MDU_EN adds mult/div sequencing through a fixed-latency MDWAIT state.
module mc_controller #(
  parameter int ALU_W  = 4,
  parameter int MD_LAT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             dm_ack,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             dm_req,
  output logic             mem_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       to_reg,
  output logic [1:0]       ext_sel,
  output logic             alu_src,
  output logic [ALU_W-1:0] alu_op,
  output logic [1:0]       npc_sel,
  output logic             md_start,
  output logic             md_busy,
  output logic             instr_done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_MDWAIT = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d, OP_LUI = 6'h0f, OP_LW  = 6'h23, OP_SW  = 6'h2b;
  localparam logic [5:0] F_JR     = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23;

  if (MD_LAT < 1) begin : g_md_lat_check
    $error("MD_LAT must be at least 1");
  end

  state_t cur, nxt;

  logic is_r, is_addu, is_subu, is_jr, is_j, is_jal, is_beq;
  logic is_ori, is_lui, is_lw, is_sw, is_md, is_mf, go_exec;

  assign is_r    = (op == OP_RTYPE);
  assign is_addu = is_r && (func == F_ADDU);
  assign is_subu = is_r && (func == F_SUBU);
  assign is_jr   = is_r && (func == F_JR);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign is_beq  = (op == OP_BEQ);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);

`ifdef MC_CTRL_MDU_EN
  localparam int unsigned CNT_W = $clog2(MD_LAT + 1);
  logic [CNT_W-1:0] cnt;

  assign is_md   = is_r && ((func == 6'h18) || (func == 6'h1a));
  assign is_mf   = is_r && ((func == 6'h10) || (func == 6'h12));
  assign md_busy = (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        cnt <= '0;
    else if (md_start)                   cnt <= CNT_W'(MD_LAT);
    else if (cur == S_MDWAIT && cnt != '0) cnt <= cnt - 1'b1;
  end
`else
  assign is_md   = 1'b0;
  assign is_mf   = 1'b0;
  assign md_busy = 1'b0;
`endif

  assign go_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_md | is_mf;
  assign state   = cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= S_IDLE;
    else          cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    dm_req     = 1'b0;
    mem_we     = 1'b0;
    reg_dst    = 2'd0;
    to_reg     = 2'd0;
    ext_sel    = 2'd0;
    alu_src    = 1'b0;
    alu_op     = '0;
    npc_sel    = 2'd0;
    md_start   = 1'b0;
    instr_done = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        nxt   = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jr) begin
          pc_we      = 1'b1;
          npc_sel    = is_jr ? 2'd3 : 2'd2;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else if (is_jal) begin
          // PC jumps here; WB later writes the link address into $31
          pc_we   = 1'b1;
          npc_sel = 2'd2;
          nxt     = S_WB;
        end else if (go_exec) begin
          nxt = S_EXEC;
        end else begin
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_subu)             alu_op = ALU_W'(1);
        if (is_ori) begin
          alu_op  = ALU_W'(2);
          alu_src = 1'b1;
        end
        if (is_lui) begin
          ext_sel = 2'd2;
          alu_src = 1'b1;
        end
        if (is_lw || is_sw) begin
          ext_sel = 2'd1;
          alu_src = 1'b1;
        end
        if (is_beq) begin
          alu_op     = ALU_W'(1);
          pc_we      = zero;
          npc_sel    = 2'd1;
          ext_sel    = 2'd1;
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else if (is_md) begin
          md_start = 1'b1;
          nxt      = S_MDWAIT;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dm_req = 1'b1;
        mem_we = is_sw;
        if (dm_ack) begin
          instr_done = is_sw;
          nxt        = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
        if (is_jal) begin
          reg_dst = 2'd2;
          to_reg  = 2'd2;
        end else if (is_lw) begin
          to_reg = 2'd1;
        end else if (is_mf) begin
          reg_dst = 2'd1;
          to_reg  = 2'd3;
        end else if (is_r) begin
          reg_dst = 2'd1;
        end
      end
`ifdef MC_CTRL_MDU_EN
      S_MDWAIT: begin
        // counter reaches 0 on the same edge that leaves MDWAIT
        if (cnt <= CNT_W'(1)) begin
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle `Controller` decoder for the MIPS core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It drives the datapath enables and mux selects from the latched `op`/`func`, holds in MEM on a data-memory request/acknowledge handshake, and optionally sequences a fixed-latency multiply/divide unit. It sits between the instruction register and the multi-cycle datapath, replacing the combinational controller.

## Interface
- `ALU_W`, 4: width of `alu_op`.
- `MD_LAT`, 4: multiply/divide busy cycles, must be ≥1.

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode from the instruction register
- `func`  in  6  function field from the instruction register
- `zero`  in  1  ALU equality flag, valid in EXEC
- `dm_ack`  in  1  data-memory acknowledge
- `pc_we`, `ir_we`, `reg_we`  out  1 each  PC, IR and GRF write enables
- `dm_req`, `mem_we`  out  1 each  data-memory request and write
- `reg_dst`  out  2  0=rt, 1=rd, 2=$31
- `to_reg`  out  2  0=ALU, 1=mem, 2=PC+4, 3=HI/LO
- `ext_sel`  out  2  0=zero-extend, 1=sign-extend, 2=lui
- `alu_src`  out  1  1 selects the immediate
- `alu_op`  out  ALU_W  0=add, 1=sub, 2=or
- `npc_sel`  out  2  0=PC+4, 1=branch, 2=j/jal, 3=jr
- `md_start`, `md_busy`  out  1 each  MDU start pulse and busy flag
- `instr_done`  out  1  one-cycle retire pulse
- `state`  out  3  current state, for debug

## Operation
- States are IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, MDWAIT=6. Outputs are decoded combinationally from `state` and `op`/`func`.
- IDLE is the reset state. All outputs are 0 in IDLE. IDLE goes to FETCH unconditionally.
- FETCH: `ir_we=1`, `pc_we=1`, `npc_sel=0`. Goes to DECODE.
- DECODE:
  - j: `pc_we=1`, `npc_sel=2`, retire, go to FETCH.
  - jr: `pc_we=1`, `npc_sel=3`, retire, go to FETCH.
  - jal: go to WB.
  - Undefined op/func (including nop): retire, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - addu: `alu_op=0`. subu: `alu_op=1`. ori: `alu_op=2`, `ext_sel=0`, `alu_src=1`. lui: `ext_sel=2`, `alu_src=1`, `alu_op=0`. lw/sw: `ext_sel=1`, `alu_src=1`, `alu_op=0`.
  - beq: `alu_op=1`; `pc_we=zero`, `npc_sel=1`, `ext_sel=1`; retire, go to FETCH.
  - lw/sw go to MEM. addu, subu, ori, lui, mfhi and mflo go to WB.
- MEM:
  - `dm_req=1` is held every cycle in MEM. `mem_we=1` is held for sw.
  - Leave on the edge where `dm_ack=1`: lw goes to WB; sw retires and goes to FETCH.
  - `dm_ack` already high on MEM entry gives a one-cycle MEM. `dm_ack` outside MEM is ignored.
- WB: `reg_we=1`, retire, go to FETCH.
  - R-type: `reg_dst=1`, `to_reg=0`.
  - ori/lui: `reg_dst=0`, `to_reg=0`.
  - lw: `reg_dst=0`, `to_reg=1`.
  - jal: `reg_dst=2`, `to_reg=2`.
  - mfhi/mflo: `reg_dst=1`, `to_reg=3`.
- Retire: `instr_done=1` for exactly the final cycle of each instruction.

## Timing
- Cycles per instruction (`dm_ack` immediate):
  - j, jr, undefined: 2
  - beq, jal: 3
  - addu, subu, ori, lui, sw, mfhi, mflo: 4
  - lw: 5
- Each `dm_ack` wait cycle adds one cycle to lw and sw.
- `reset_n` low forces IDLE immediately, mid-instruction included. All enables drop the same instant, with no clock needed. The MDU counter clears to 0.
- The first FETCH is the second rising edge after `reset_n` deasserts.
- The `state` register and the MDU counter are the only flops.

## Configuration
- `MC_CTRL_MDU_EN` defined:
  - mult (`func` 0x18) and div (`func` 0x1A): EXEC asserts `md_start` for 1 cycle, loads counter=MD_LAT, then goes to MDWAIT.
  - MDWAIT decrements the counter each cycle. `md_busy` = (counter≠0).
  - The counter's transition to 0 occurs on the edge that leaves MDWAIT. `instr_done` is asserted in MDWAIT's final cycle, and the next state is FETCH.
  - mult/div total cycles = 3+MD_LAT.
  - mfhi (`func` 0x10) and mflo (`func` 0x12) are decoded as described in Operation.
- `MC_CTRL_MDU_EN` undefined: these four functs are undefined (2-cycle retire). MDWAIT, the counter and `md_start` are absent. `md_busy` is tied to 0.

## Test plan
- Reset release, then addu (op 0, `func` 0x21) → state 0,1,2,3,5; `reg_we=1`, `reg_dst=1` in cycle 4; `instr_done` in cycle 4 only.
- lw (op 0x23) with `dm_ack` held low 3 MEM cycles → MEM lasts 4 cycles with `dm_req` steady; WB `to_reg=1`; total 8 cycles.
- beq (op 0x04): with `zero=1` → `pc_we=1`, `npc_sel=1` in EXEC; with `zero=0` → `pc_we=0`; both 3 cycles.
- jal (op 0x03) → DECODE has `pc_we=1`, `npc_sel=2`; WB has `reg_dst=2`, `to_reg=2`; 3 cycles.
- `reset_n` pulsed low during MEM of sw → `mem_we` and `dm_req` drop asynchronously; `state`=0; the next FETCH arrives 2 edges after release.
- With `MC_CTRL_MDU_EN`, MD_LAT=4, mult → `md_start` for 1 cycle, `md_busy` high 4 cycles, 7 cycles total. Without the macro → 2-cycle retire and `md_busy=0`.
